lcd_refresh_sched: RTL

Frame refresh scheduler for the CSTN panel path. It sits between the framebuffer memory port and the 48-bit pixel FIFO that feeds the panel timing controller. Each frame it prefills the FIFO, pulses the panel controller's frame-start input, and streams the rest of the frame in fixed bursts, throttled by FIFO fill level. It also owns front/back framebuffer selection and applies buffer swaps only on frame boundaries.

---
 rtl/lcd_refresh_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_refresh_sched.sv
// lcd_refresh_sched: per-frame FIFO prefill, vsync pulse and FIFO-throttled burst fetch from framebuffer memory.
// Double buffering is compiled in when LCD_SCHED_DBUF_EN is defined.
`default_nettype none

module lcd_refresh_sched #(
  parameter int unsigned FB_BASE0      = 32'h0000,
  parameter int unsigned FB_BASE1      = 32'h4B00,
  parameter int          ADDR_W        = 16,
  parameter int unsigned TOTAL_WORDS   = 19200,
  parameter int unsigned BURST         = 8,
  parameter int unsigned PREFILL_WORDS = 64,
  parameter int unsigned FIFO_DEPTH    = 128,
  parameter int          LVL_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [47:0]       mem_rdata,
  output logic              fifo_we,
  output logic [47:0]       fifo_wdata,
  input  logic [LVL_W-1:0]  fifo_level,
  output logic              vsync_out,
  input  logic              buf_swap_req,
  output logic              swap_ack,
  output logic              buf_sel,
  output logic              busy,
  output logic              frame_skip
);

  localparam int WC_W = $clog2(TOTAL_WORDS + 1);
  localparam int BC_W = $clog2(BURST + 1);

  localparam logic [WC_W-1:0]   TOTAL_C    = WC_W'(TOTAL_WORDS);
  localparam logic [WC_W-1:0]   PREFILL_C  = WC_W'(PREFILL_WORDS);
  localparam logic [BC_W-1:0]   BURST_LAST = BC_W'(BURST - 1);
  localparam logic [ADDR_W-1:0] BASE0_C    = ADDR_W'(FB_BASE0);
  localparam logic [ADDR_W-1:0] BASE1_C    = ADDR_W'(FB_BASE1);
  // One extra slot of headroom absorbs the write still in the output register.
  localparam int unsigned       SPACE_MAX  = FIFO_DEPTH - BURST - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [WC_W-1:0]   word_cnt, word_nxt;
  logic [BC_W-1:0]   beat_cnt, beat_nxt;
  logic              vs_done, vs_done_nxt;
  logic              busy_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] maddr_nxt;
  logic              we_nxt;
  logic [47:0]       wdata_nxt;
  logic              vsync_nxt;
  logic              skip_nxt;
  logic              start_frame;
  logic              has_space;
  logic              buf_sel_nxt;

  assign start_frame = (state == IDLE) && frame_start;
  assign has_space   = (32'(fifo_level) <= SPACE_MAX);

`ifdef LCD_SCHED_DBUF_EN
  logic pending, pending_nxt, swap_ack_nxt;

  // A request arriving together with the applied frame_start takes effect on that frame.
  always_comb begin
    pending_nxt  = pending | buf_swap_req;
    buf_sel_nxt  = buf_sel;
    swap_ack_nxt = 1'b0;
    if (start_frame && (pending || buf_swap_req)) begin
      buf_sel_nxt  = ~buf_sel;
      swap_ack_nxt = 1'b1;
      pending_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= 1'b0;
      buf_sel  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      buf_sel  <= buf_sel_nxt;
      swap_ack <= swap_ack_nxt;
    end
  end
`else
  logic unused_swap_req;

  assign unused_swap_req = buf_swap_req;
  assign buf_sel_nxt     = 1'b0;
  assign buf_sel         = 1'b0;
  assign swap_ack        = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    word_nxt    = word_cnt;
    beat_nxt    = beat_cnt;
    vs_done_nxt = vs_done;
    busy_nxt    = busy;
    req_nxt     = mem_req;
    maddr_nxt   = mem_addr;
    we_nxt      = 1'b0;
    wdata_nxt   = fifo_wdata;
    vsync_nxt   = 1'b0;
    skip_nxt    = frame_start && (state != IDLE);

    case (state)
      IDLE: begin
        if (frame_start) begin
          addr_nxt    = buf_sel_nxt ? BASE1_C : BASE0_C;
          word_nxt    = '0;
          beat_nxt    = '0;
          vs_done_nxt = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (mem_req) begin
          if (mem_gnt) begin
            req_nxt   = 1'b0;
            state_nxt = DATA;
          end
        end else if (has_space) begin
          req_nxt   = 1'b1;
          maddr_nxt = addr;
        end
      end
      DATA: begin
        if (mem_rvalid) begin
          we_nxt    = 1'b1;
          wdata_nxt = mem_rdata;
          addr_nxt  = addr + ADDR_W'(1);
          word_nxt  = word_cnt + WC_W'(1);
          if (beat_cnt == BURST_LAST) begin
            beat_nxt  = '0;
            state_nxt = (word_nxt == TOTAL_C) ? DONE : REQ;
          end else begin
            beat_nxt  = beat_cnt + BC_W'(1);
          end
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // word_cnt reaches the prefill count on the same edge its FIFO write is registered.
    if ((state != IDLE) && !vs_done && (word_cnt == PREFILL_C)) begin
      vsync_nxt   = 1'b1;
      vs_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      word_cnt   <= '0;
      beat_cnt   <= '0;
      vs_done    <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fifo_we    <= 1'b0;
      fifo_wdata <= '0;
      vsync_out  <= 1'b0;
      frame_skip <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      word_cnt   <= word_nxt;
      beat_cnt   <= beat_nxt;
      vs_done    <= vs_done_nxt;
      busy       <= busy_nxt;
      mem_req    <= req_nxt;
      mem_addr   <= maddr_nxt;
      fifo_we    <= we_nxt;
      fifo_wdata <= wdata_nxt;
      vsync_out  <= vsync_nxt;
      frame_skip <= skip_nxt;
    end
  end

endmodule

`default_nettype wire
